// File: rtl/round_key_sequencer.sv
`timescale 1ns/1ps
// AES-128 round key sequencer: loads a cipher key and streams round keys 0..10 over valid/ready.
// Optional random-access key store enabled by defining ROUND_KEY_STORE_EN.
module round_key_sequencer (
    input  logic         clk,
    input  logic         nReset,
    input  logic         keyValid,
    output logic         keyReady,
    input  logic [127:0] cipherKey,
    output logic         rkValid,
    input  logic         rkReady,
    output logic [3:0]   rkRound,
    output logic [127:0] rkData,
    output logic         done,
    input  logic         rdEn,
    input  logic [3:0]   rdRound,
    output logic [127:0] rdKey
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [127:0]   cur_key_q;
    logic [3:0]     round_q;
    logic           key_ready_q;
    logic           rk_valid_q;
    logic           done_q;
    logic [127:0]   key_exp_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(rnd), 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = w3        ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign key_exp_d = expand_key(cur_key_q, round_q + 4'd1);

    // Schedule FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            cur_key_q   <= 128'd0;
            round_q     <= 4'd0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (keyValid) begin
                        state_q     <= ST_EMIT;
                        cur_key_q   <= cipherKey;
                        round_q     <= 4'd0;
                        key_ready_q <= 1'b0;
                        rk_valid_q  <= 1'b1;
                        done_q      <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_EMIT: begin
                    if (rkReady && (round_q < 4'd10)) begin
                        cur_key_q <= key_exp_d;
                        round_q   <= round_q + 4'd1;
                    end else if (rkReady) begin
                        state_q     <= ST_DONE;
                        key_ready_q <= 1'b1;
                        rk_valid_q  <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    round_q     <= 4'd0;
                    key_ready_q <= 1'b1;
                    rk_valid_q  <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign keyReady = key_ready_q;
    assign rkValid  = rk_valid_q;
    assign rkRound  = round_q;
    assign rkData   = cur_key_q;
    assign done     = done_q;

`ifdef ROUND_KEY_STORE_EN
    logic [127:0] store_q [0:10];
    logic [127:0] rd_key_q;

    // Capture every accepted round key at its round index.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 11; i++) begin
                store_q[i] <= 128'd0;
            end
        end else if (rk_valid_q && rkReady) begin
            store_q[round_q] <= cur_key_q;
        end else begin
            store_q <= store_q;
        end
    end

    // Registered read; sees pre-edge contents so a same-cycle write returns old data.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_key_q <= 128'd0;
        end else if (rdEn) begin
            rd_key_q <= (rdRound <= 4'd10) ? store_q[rdRound] : 128'd0;
        end else begin
            rd_key_q <= rd_key_q;
        end
    end

    assign rdKey = rd_key_q;
`else
    logic unused_rd_s;
    assign unused_rd_s = ^{rdEn, rdRound};
    assign rdKey       = 128'd0;
`endif

endmodule

// File: tb/tb_round_key_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for round_key_sequencer: FIPS-197 vectors, backpressure, back-to-back, reset, store.
module tb_round_key_sequencer;

    logic         clk = 1'b0;
    logic         nReset;
    logic         keyValid;
    logic         keyReady;
    logic [127:0] cipherKey;
    logic         rkValid;
    logic         rkReady;
    logic [3:0]   rkRound;
    logic [127:0] rkData;
    logic         done;
    logic         rdEn;
    logic [3:0]   rdRound;
    logic [127:0] rdKey;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] prev_rk [0:10];
    logic [127:0] got_rk [0:10];

    typedef struct {
        logic [127:0] key;
        int           rnd;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [0:3];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    round_key_sequencer dut (
        .clk       (clk),
        .nReset    (nReset),
        .keyValid  (keyValid),
        .keyReady  (keyReady),
        .cipherKey (cipherKey),
        .rkValid   (rkValid),
        .rkReady   (rkReady),
        .rkRound   (rkRound),
        .rkData    (rkData),
        .done      (done),
        .rdEn      (rdEn),
        .rdRound   (rdRound),
        .rdKey     (rdKey)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // S-box via the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    // Full 44-word FIPS-197 key expansion, sliced into 11 round keys.
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic run_schedule(input logic [127:0] key, input int ready_pct, input bit rbw);
        int idx;
        int cycles;
        bit rd_now;
        for (int r = 0; r < 11; r++) prev_rk[r] = exp_rk[r];
        compute_model(key);
        cycles = 0;
        while (!keyReady && cycles < 20) begin
            step();
            cycles++;
        end
        chk("key_ready_before_load", 128'(keyReady), 128'd1);
        cipherKey = key;
        keyValid  = 1'b1;
        step();
        keyValid  = 1'b0;
        chk("done_clear_on_load", 128'(done), 128'd0);
        idx = 0;
        cycles = 0;
        while (idx <= 10 && cycles < 300) begin
            chk("rk_valid", 128'(rkValid), 128'd1);
            chk("rk_round", 128'(rkRound), 128'(idx));
            chk("rk_data", rkData, exp_rk[idx]);
            chk("key_ready_emit", 128'(keyReady), 128'd0);
            chk("done_emit", 128'(done), 128'd0);
            got_rk[idx] = rkData;
            rkReady = ($urandom_range(99) < ready_pct);
            if (ready_pct < 100) begin
                keyValid  = ($urandom_range(3) == 0);
                cipherKey = {$urandom, $urandom, $urandom, $urandom};
            end
            rd_now = rbw && (idx == 0) && rkReady;
            if (rd_now) begin
                rdEn    = 1'b1;
                rdRound = 4'd0;
            end
            step();
            cycles++;
            keyValid = 1'b0;
            rdEn     = 1'b0;
            if (rd_now) begin
`ifdef ROUND_KEY_STORE_EN
                chk("read_before_write", rdKey, prev_rk[0]);
`else
                chk("read_before_write", rdKey, 128'd0);
`endif
            end
            if (rkReady) idx++;
        end
        rkReady = 1'b0;
        chk("schedule_complete", 128'(idx), 128'd11);
        if (ready_pct >= 100) chk("stream_latency", 128'(cycles), 128'd11);
        chk("done_set", 128'(done), 128'd1);
        chk("key_ready_done", 128'(keyReady), 128'd1);
        chk("rk_valid_done", 128'(rkValid), 128'd0);
    endtask

    initial begin
        nReset    = 1'b0;
        keyValid  = 1'b0;
        cipherKey = 128'd0;
        rkReady   = 1'b0;
        rdEn      = 1'b0;
        rdRound   = 4'd0;
        build_sbox();
        for (int r = 0; r < 11; r++) exp_rk[r] = 128'd0;

        vecs[0] = '{key: FIPS_KEY, rnd: 0,  exp: FIPS_KEY};
        vecs[1] = '{key: FIPS_KEY, rnd: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{key: FIPS_KEY, rnd: 10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{key: SEQ_KEY,  rnd: 10, exp: 128'h13111d7fe3944a17f307a78b4d2b30c5};

        #12;
        chk("reset_key_ready", 128'(keyReady), 128'd1);
        chk("reset_rk_valid", 128'(rkValid), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_rk_round", 128'(rkRound), 128'd0);
        chk("reset_rk_data", rkData, 128'd0);
        chk("reset_rd_key", rdKey, 128'd0);
        @(negedge clk);
        nReset = 1'b1;
        step();

        // Known-answer vectors; consecutive entries also exercise loads straight from DONE.
        for (int v = 0; v < 4; v++) begin
            run_schedule(vecs[v].key, 100, 1'b0);
            chk($sformatf("vector%0d_round%0d", v, vecs[v].rnd), got_rk[vecs[v].rnd], vecs[v].exp);
        end

        // Store readback after a FIPS-197 run, rounds 10 down to 0.
        run_schedule(FIPS_KEY, 100, 1'b0);
        for (int r = 10; r >= 0; r--) begin
            rdEn    = 1'b1;
            rdRound = 4'(r);
            step();
`ifdef ROUND_KEY_STORE_EN
            chk($sformatf("store_read_%0d", r), rdKey, exp_rk[r]);
`else
            chk($sformatf("store_read_%0d", r), rdKey, 128'd0);
`endif
        end
        rdRound = 4'd12;
        step();
        chk("store_read_oob", rdKey, 128'd0);
        rdRound = 4'd3;
        step();
        rdEn = 1'b0;
        rdRound = 4'd7;
        step();
`ifdef ROUND_KEY_STORE_EN
        chk("store_read_hold", rdKey, exp_rk[3]);
`else
        chk("store_read_hold", rdKey, 128'd0);
`endif

        // Same-cycle read and stream write of index 0 returns the previous key's entry.
        run_schedule(SEQ_KEY, 100, 1'b1);

        // Random keys with backpressure and spurious keyValid during EMIT.
        for (int n = 0; n < 6; n++) begin
            run_schedule({$urandom, $urandom, $urandom, $urandom}, 50, 1'b0);
        end

        // Asynchronous reset in the middle of a schedule.
        cipherKey = FIPS_KEY;
        keyValid  = 1'b1;
        rkReady   = 1'b1;
        step();
        keyValid  = 1'b0;
        repeat (5) step();
        chk("pre_reset_round", 128'(rkRound), 128'd5);
        #2;
        nReset = 1'b0;
        #1;
        chk("async_rst_rk_valid", 128'(rkValid), 128'd0);
        chk("async_rst_key_ready", 128'(keyReady), 128'd1);
        chk("async_rst_done", 128'(done), 128'd0);
        chk("async_rst_rk_round", 128'(rkRound), 128'd0);
        chk("async_rst_rd_key", rdKey, 128'd0);
        rkReady = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        rdEn    = 1'b1;
        rdRound = 4'd3;
        step();
        rdEn = 1'b0;
        chk("store_cleared", rdKey, 128'd0);
        chk("post_reset_idle", 128'(rkValid), 128'd0);
        run_schedule(FIPS_KEY, 100, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
